// File: rtl/input_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// input_debouncer_pkg
//   Shared definitions for the input debouncer and the GPIO block that reuses
//   its default timing.
//
//   Contents:
//     state_t                  2-bit debouncer FSM state encoding
//     DEFAULT_CNT_W            default debounce counter width
//     DEFAULT_DEBOUNCE_CYCLES  default number of qualified ticks a new level
//                              must persist before it is accepted
//     debounce_cycles_legal()  range check used at elaboration time
// -----------------------------------------------------------------------------
package input_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_t;

    localparam int DEFAULT_CNT_W           = 16;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;

    // A count of zero would accept a level without any persistence, and a
    // count that does not fit the counter could never reach its terminal value.
    function automatic bit debounce_cycles_legal(input int cycles, input int width);
        longint max_cycles;
        max_cycles = (longint'(1) << width) - longint'(1);
        return (cycles >= 1) && (longint'(cycles) <= max_cycles);
    endfunction

endpackage : input_debouncer_pkg

// File: rtl/input_debouncer_counter.sv
// -----------------------------------------------------------------------------
// debounce_counter
//   Counts qualified ticks while the debouncer is checking a candidate level.
//   The count saturates at DEBOUNCE_CYCLES-1 and never wraps.
//
//   Ports:
//     clk       system clock, rising edge
//     srst      synchronous active-high reset
//     clear     force the count back to zero (priority over enable)
//     enable    advance the count by one (the qualified tick)
//     terminal  high while the count equals DEBOUNCE_CYCLES-1
// -----------------------------------------------------------------------------
module debounce_counter
    import input_debouncer_pkg::*;
#(
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // NOTE: registered state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            // Holding at the terminal value keeps the counter from wrapping
            // if the FSM lingers on the completing edge.
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == LAST_COUNT);

endmodule : debounce_counter

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//   Counter-based debounce filter for one synchronised input level. A new
//   level must be seen continuously for DEBOUNCE_CYCLES qualified ticks before
//   the debounced output follows it. Any revert during the check (whether or
//   not tick is high) rejects the change without a pulse.
//
//   Ports:
//     clk    system clock, all logic on the rising edge
//     srst   synchronous active-high reset, priority over all other inputs
//     in     synchronised raw level
//     tick   sample-qualify strobe; tie high for per-clock debounce
//     level  debounced level (registered)
//     rise   one-cycle pulse in the cycle level goes 0->1 (registered)
//     fall   one-cycle pulse in the cycle level goes 1->0 (registered)
// -----------------------------------------------------------------------------
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic srst,
    input  logic in,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);

    if (!debounce_cycles_legal(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_cycles
        $error("input_debouncer: DEBOUNCE_CYCLES=%0d outside 1..2^%0d-1",
               DEBOUNCE_CYCLES, CNT_W);
    end

    state_t state;
    logic   cnt_clear;
    logic   cnt_enable;
    logic   cnt_terminal;

    // The counter only runs while a candidate level is being held; in the
    // stable states and on a revert it is parked at zero, so every check
    // starts from a clean count.
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_clear  = 1'b1;
        cnt_enable = 1'b0;
        unique case (state)
            CHECK_HIGH: begin
                if (in) begin
                    cnt_clear  = 1'b0;
                    cnt_enable = tick;
                end
            end
            CHECK_LOW: begin
                if (!in) begin
                    cnt_clear  = 1'b0;
                    cnt_enable = tick;
                end
            end
            default: ;
        endcase
    end

    debounce_counter #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_counter (
        .clk      (clk),
        .srst     (srst),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .terminal (cnt_terminal)
    );

    // FSM and output registers. rise/fall default low every cycle so they
    // can only be one cycle wide. The revert test comes before the
    // completion test, so a bounce on the terminal edge wins.
    always_ff @(posedge clk) begin
        if (srst) begin
            state <= STABLE_LOW;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            unique case (state)
                STABLE_LOW: begin
                    if (in) state <= CHECK_HIGH;
                end
                CHECK_HIGH: begin
                    if (!in) begin
                        state <= STABLE_LOW;
                    end else if (tick && cnt_terminal) begin
                        state <= STABLE_HIGH;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!in) state <= CHECK_LOW;
                end
                CHECK_LOW: begin
                    if (in) begin
                        state <= STABLE_HIGH;
                    end else if (tick && cnt_terminal) begin
                        state <= STABLE_LOW;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end
                end
                default: state <= STABLE_LOW;
            endcase
        end
    end

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//   Drives two debouncers (DEBOUNCE_CYCLES=4 and =1) with the same stimulus:
//   directed sequences followed by random traffic. A reference model tracks,
//   for each instance, the run of consecutive samples that differ from the
//   accepted level and the tick history of that run; the level flips when the
//   ticks after the run's first sample add up to DEBOUNCE_CYCLES.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

    localparam int RUN_MAX = 4096;

    logic clk = 1'b0;
    logic srst;
    logic in_d;
    logic tick_d;

    logic level4, rise4, fall4;
    logic level1, rise1, fall1;

    int passed = 0;
    int total  = 0;

    // Reference model state, index 0 -> D=4 instance, index 1 -> D=1 instance
    int m_run_len  [2];
    bit m_run_tick [2][RUN_MAX];
    bit m_level    [2];
    bit m_rise     [2];
    bit m_fall     [2];

    always #5 clk = ~clk;

    input_debouncer #(.CNT_W(16), .DEBOUNCE_CYCLES(4)) u_dut4 (
        .clk   (clk),
        .srst  (srst),
        .in    (in_d),
        .tick  (tick_d),
        .level (level4),
        .rise  (rise4),
        .fall  (fall4)
    );

    input_debouncer #(.CNT_W(4), .DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .srst  (srst),
        .in    (in_d),
        .tick  (tick_d),
        .level (level1),
        .rise  (rise1),
        .fall  (fall1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            passed++;
    endtask

    task automatic model_step(input int k, input int d, input bit i, input bit t, input bit r);
        int qual;
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
        if (r) begin
            m_level[k]   = 1'b0;
            m_run_len[k] = 0;
        end else if (i == m_level[k]) begin
            m_run_len[k] = 0;
        end else begin
            if (m_run_len[k] < RUN_MAX) m_run_tick[k][m_run_len[k]] = t;
            m_run_len[k]++;
            // The first differing sample only opens the check; qualified
            // ticks are counted from the following samples onward.
            qual = 0;
            for (int j = 1; j < m_run_len[k] && j < RUN_MAX; j++)
                qual += int'(m_run_tick[k][j]);
            if (qual == d) begin
                m_level[k]   = i;
                m_rise[k]    = i;
                m_fall[k]    = !i;
                m_run_len[k] = 0;
            end
        end
    endtask

    // Called at a falling edge; applies inputs, lets one rising edge sample
    // them, then compares outputs 1 time unit after that edge.
    task automatic step(input bit i, input bit t, input bit r);
        in_d   = i;
        tick_d = t;
        srst   = r;
        @(posedge clk);
        #1;
        model_step(0, 4, i, t, r);
        model_step(1, 1, i, t, r);
        check("level_d4", 32'(level4), 32'(m_level[0]));
        check("rise_d4",  32'(rise4),  32'(m_rise[0]));
        check("fall_d4",  32'(fall4),  32'(m_fall[0]));
        check("level_d1", 32'(level1), 32'(m_level[1]));
        check("rise_d1",  32'(rise1),  32'(m_rise[1]));
        check("fall_d1",  32'(fall1),  32'(m_fall[1]));
        check("rise_fall_excl", 32'(rise4 & fall4) | 32'(rise1 & fall1), 32'(0));
        @(negedge clk);
    endtask

    task automatic hold(input bit i, input bit t, input int n);
        for (int c = 0; c < n; c++) step(i, t, 1'b0);
    endtask

    initial begin
        bit cur_in;
        for (int k = 0; k < 2; k++) begin
            m_run_len[k] = 0;
            m_level[k]   = 1'b0;
            m_rise[k]    = 1'b0;
            m_fall[k]    = 1'b0;
        end
        srst   = 1'b1;
        in_d   = 1'b0;
        tick_d = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);

        // Rise with tick tied high, then hold high
        hold(1'b1, 1'b1, 8);
        // Fall path
        hold(1'b0, 1'b1, 8);
        // Bounce: 3 highs then low, then a long high
        hold(1'b1, 1'b1, 3);
        hold(1'b0, 1'b1, 3);
        hold(1'b1, 1'b1, 7);
        // Bounce exactly on the terminal edge of the falling check
        hold(1'b0, 1'b1, 4);
        hold(1'b1, 1'b1, 3);
        hold(1'b0, 1'b1, 8);

        // Tick every third cycle, in held high
        for (int c = 0; c < 18; c++) step(1'b1, (c % 3) == 2, 1'b0);
        // Revert while tick is low still rejects
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        hold(1'b1, 1'b1, 2);

        // Reset in the middle of a falling check
        hold(1'b0, 1'b1, 2);
        step(1'b0, 1'b1, 1'b1);
        hold(1'b0, 1'b1, 6);

        // Single-cycle glitch, then a short high held
        step(1'b1, 1'b1, 1'b0);
        hold(1'b0, 1'b1, 3);
        hold(1'b1, 1'b1, 3);
        hold(1'b0, 1'b1, 3);

        // Random traffic: sticky input, random tick, occasional reset
        cur_in = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) cur_in = !cur_in;
            step(cur_in, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end
        // Random traffic with tick tied high and longer holds
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 7) == 0) cur_in = !cur_in;
            step(cur_in, 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_input_debouncer
